power_trigger: RTL and testbench



---
 rtl/power_trigger.sv | 184 ++++++++++++++++++
 tb/tb_power_trigger.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_trigger.sv
// Sliding-window power averager with a debounced, hysteretic threshold trigger.
// Optional peak reporting for each trigger burst is enabled by defining POWER_TRIGGER_PEAK_EN.
module power_trigger #(
    parameter int WINDOW_LOG2 = 4,
    parameter int HOLD_ON     = 4,
    parameter int HOLD_OFF    = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic [31:0] mag_sq,
    input  logic        mag_sq_valid,
    input  logic [31:0] threshold,
    output logic [31:0] pwr_avg,
    output logic        pwr_avg_valid,
    output logic        trigger,
    output logic        window_full
`ifdef POWER_TRIGGER_PEAK_EN
    ,
    output logic [31:0] peak_pwr,
    output logic        peak_valid
`endif
);

    localparam int W     = 1 << WINDOW_LOG2;
    localparam int SUM_W = 32 + WINDOW_LOG2;
    localparam int PTR_W = WINDOW_LOG2;
    localparam int CNT_W = WINDOW_LOG2 + 1;

    typedef enum logic [1:0] {
        ST_FILL,
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic             accept;
    logic             buf_full;
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_addr;
    logic [CNT_W-1:0] fill_cnt_reg;
    logic [SUM_W-1:0] sum_reg;
    logic [SUM_W-1:0] sum_next;
    logic [31:0]      delay_mem [W];
    logic [31:0]      oldest_reg;
    logic [31:0]      pwr_avg_reg;
    logic             pwr_avg_valid_reg;
    logic             window_full_reg;

    state_t           state_reg;
    logic [7:0]       on_cnt_reg;
    logic [7:0]       off_cnt_reg;
    logic             trigger_reg;
    logic             above;
    logic [8:0]       on_inc;
    logic [8:0]       off_inc;
    logic             on_hit;
    logic             off_hit;

    assign accept   = enable && mag_sq_valid;
    assign buf_full = (fill_cnt_reg == CNT_W'(W));

    // Prefetch the next oldest entry so the RAM read stays registered; the
    // address being written on an accept is never the one being read.
    assign rd_addr  = accept ? (wr_ptr_reg + PTR_W'(1)) : wr_ptr_reg;

    assign sum_next = sum_reg + SUM_W'(mag_sq)
                      - (buf_full ? SUM_W'(oldest_reg) : SUM_W'(0));

    always_ff @(posedge clock) begin
        if (accept) begin
            delay_mem[wr_ptr_reg] <= mag_sq;
        end
        oldest_reg <= delay_mem[rd_addr];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg        <= '0;
            fill_cnt_reg      <= '0;
            sum_reg           <= '0;
            pwr_avg_reg       <= '0;
            pwr_avg_valid_reg <= 1'b0;
            window_full_reg   <= 1'b0;
        end else begin
            pwr_avg_valid_reg <= accept;
            if (accept) begin
                wr_ptr_reg  <= wr_ptr_reg + PTR_W'(1);
                sum_reg     <= sum_next;
                pwr_avg_reg <= sum_next[SUM_W-1:WINDOW_LOG2];
                if (!buf_full) begin
                    fill_cnt_reg <= fill_cnt_reg + CNT_W'(1);
                end
                if (fill_cnt_reg == CNT_W'(W - 1)) begin
                    window_full_reg <= 1'b1;
                end
            end
        end
    end

    assign above   = pwr_avg_reg > threshold;
    assign on_inc  = {1'b0, on_cnt_reg} + 9'd1;
    assign off_inc = {1'b0, off_cnt_reg} + 9'd1;
    assign on_hit  = above && (on_inc == 9'(HOLD_ON));
    assign off_hit = !above && (off_inc == 9'(HOLD_OFF));

`ifdef POWER_TRIGGER_PEAK_EN
    logic [31:0] peak_track_reg;
    logic [31:0] peak_cand;
    logic [31:0] peak_pwr_reg;
    logic        peak_valid_reg;

    assign peak_cand = (pwr_avg_reg > peak_track_reg) ? pwr_avg_reg : peak_track_reg;
`endif

    // The FSM follows pwr_avg_valid rather than enable, so an average produced
    // just before enable drops is still evaluated and no decision is lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg   <= ST_FILL;
            on_cnt_reg  <= '0;
            off_cnt_reg <= '0;
            trigger_reg <= 1'b0;
`ifdef POWER_TRIGGER_PEAK_EN
            peak_track_reg <= '0;
            peak_pwr_reg   <= '0;
            peak_valid_reg <= 1'b0;
`endif
        end else begin
`ifdef POWER_TRIGGER_PEAK_EN
            peak_valid_reg <= 1'b0;
`endif
            if (pwr_avg_valid_reg) begin
                case (state_reg)
                    ST_FILL, ST_IDLE: begin
                        // The first full-window average is judged like any IDLE one.
                        if (state_reg == ST_IDLE || window_full_reg) begin
                            if (on_hit) begin
                                trigger_reg <= 1'b1;
                                on_cnt_reg  <= '0;
                                state_reg   <= ST_ACTIVE;
                            end else begin
                                on_cnt_reg  <= above ? on_inc[7:0] : 8'd0;
                                state_reg   <= ST_IDLE;
                            end
                        end
                    end
                    ST_ACTIVE: begin
                        if (off_hit) begin
                            trigger_reg <= 1'b0;
                            off_cnt_reg <= '0;
                            state_reg   <= ST_IDLE;
`ifdef POWER_TRIGGER_PEAK_EN
                            peak_pwr_reg   <= peak_cand;
                            peak_valid_reg <= 1'b1;
                            peak_track_reg <= '0;
`endif
                        end else begin
                            off_cnt_reg <= above ? 8'd0 : off_inc[7:0];
`ifdef POWER_TRIGGER_PEAK_EN
                            peak_track_reg <= peak_cand;
`endif
                        end
                    end
                    default: begin
                        state_reg   <= ST_FILL;
                        on_cnt_reg  <= '0;
                        off_cnt_reg <= '0;
                        trigger_reg <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign pwr_avg       = pwr_avg_reg;
    assign pwr_avg_valid = pwr_avg_valid_reg;
    assign trigger       = trigger_reg;
    assign window_full   = window_full_reg;
`ifdef POWER_TRIGGER_PEAK_EN
    assign peak_pwr      = peak_pwr_reg;
    assign peak_valid    = peak_valid_reg;
`endif

endmodule

// File: tb/tb_power_trigger.sv
// Directed bench for power_trigger at default parameters (W=16, HOLD_ON=4, HOLD_OFF=8).
module tb_power_trigger;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic [31:0] mag_sq;
    logic        mag_sq_valid;
    logic [31:0] threshold;
    logic [31:0] pwr_avg;
    logic        pwr_avg_valid;
    logic        trigger;
    logic        window_full;
`ifdef POWER_TRIGGER_PEAK_EN
    logic [31:0] peak_pwr;
    logic        peak_valid;
`endif

    int total = 0;
    int bad   = 0;
    logic [31:0] hist[$];

    always #5 clock = ~clock;

    power_trigger dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .mag_sq        (mag_sq),
        .mag_sq_valid  (mag_sq_valid),
        .threshold     (threshold),
        .pwr_avg       (pwr_avg),
        .pwr_avg_valid (pwr_avg_valid),
        .trigger       (trigger),
        .window_full   (window_full)
`ifdef POWER_TRIGGER_PEAK_EN
        ,
        .peak_pwr      (peak_pwr),
        .peak_valid    (peak_valid)
`endif
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b1;
        mag_sq_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        hist.delete();
    endtask

    // Drives one accepted sample; returns the average a 16-deep window should give.
    task automatic send(input logic [31:0] v, output logic [31:0] exp_avg);
        longint unsigned s;
        mag_sq       = v;
        mag_sq_valid = 1'b1;
        enable       = 1'b1;
        tick();
        mag_sq_valid = 1'b0;
        hist.push_back(v);
        if (hist.size() > 16) void'(hist.pop_front());
        s = 0;
        foreach (hist[i]) s += longint'(hist[i]);
        exp_avg = 32'(s >> 4);
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        enable       = 1'b1;
        mag_sq_valid = 1'b1;
        mag_sq       = 32'd123;
        threshold    = '1;
        tick();
        tick();
        total++;
        if (pwr_avg !== 32'd0 || pwr_avg_valid !== 1'b0 || trigger !== 1'b0 || window_full !== 1'b0) begin
            bad++;
            $display("FAIL reset_state got avg=%0d v=%b trig=%b full=%b want 0/0/0/0", pwr_avg, pwr_avg_valid, trigger, window_full);
        end
`ifdef POWER_TRIGGER_PEAK_EN
        total++;
        if (peak_pwr !== 32'd0 || peak_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset_peak got pwr=%0d v=%b want 0/0", peak_pwr, peak_valid);
        end
`endif
        reset        = 1'b0;
        mag_sq_valid = 1'b0;
        tick();
        total++;
        if (pwr_avg_valid !== 1'b0 || pwr_avg !== 32'd0) begin
            bad++;
            $display("FAIL reset_release got avg=%0d v=%b want 0/0", pwr_avg, pwr_avg_valid);
        end
        hist.delete();
    endtask

    task automatic test_fill();
        logic [31:0] e;
        do_reset();
        threshold = '1;
        for (int k = 1; k <= 16; k++) begin
            send(32'd100, e);
            total++;
            if (pwr_avg !== e || pwr_avg_valid !== 1'b1 || window_full !== (k == 16)) begin
                bad++;
                $display("FAIL fill_%0d got avg=%0d v=%b full=%b want avg=%0d v=1 full=%b", k, pwr_avg, pwr_avg_valid, window_full, e, (k == 16));
            end
            if (k == 1 || k == 15) begin
                total++;
                if (pwr_avg !== ((k == 1) ? 32'd6 : 32'd93)) begin
                    bad++;
                    $display("FAIL fill_hand_%0d got=%0d want=%0d", k, pwr_avg, (k == 1) ? 6 : 93);
                end
            end
        end
        total++;
        if (pwr_avg !== 32'd100 || trigger !== 1'b0) begin
            bad++;
            $display("FAIL fill_final got avg=%0d trig=%b want 100/0", pwr_avg, trigger);
        end
        tick();
        total++;
        if (pwr_avg_valid !== 1'b0 || pwr_avg !== 32'd100 || window_full !== 1'b1) begin
            bad++;
            $display("FAIL fill_strobe got v=%b avg=%0d full=%b want 0/100/1", pwr_avg_valid, pwr_avg, window_full);
        end
    endtask

    task automatic test_slide();
        logic [31:0] e;
        for (int k = 1; k <= 16; k++) begin
            send(32'd0, e);
            total++;
            if (pwr_avg !== e || window_full !== 1'b1) begin
                bad++;
                $display("FAIL slide_%0d got avg=%0d full=%b want %0d/1", k, pwr_avg, window_full, e);
            end
        end
        total++;
        if (pwr_avg !== 32'd0) begin
            bad++;
            $display("FAIL slide_final got=%0d want=0", pwr_avg);
        end
        // Second lap exercises the pointer wrap again with fresh values.
        send(32'd320, e);
        total++;
        if (pwr_avg !== 32'd20) begin
            bad++;
            $display("FAIL slide_wrap got=%0d want=20", pwr_avg);
        end
    endtask

    task automatic test_trigger_on();
        logic [31:0] e;
        do_reset();
        threshold = 32'd50;
        for (int k = 1; k <= 19; k++) begin
            send(32'd100, e);
            total++;
            if (trigger !== 1'b0) begin
                bad++;
                $display("FAIL trig_on_early_%0d got=%b want=0", k, trigger);
            end
        end
        tick();
        total++;
        if (trigger !== 1'b1) begin
            bad++;
            $display("FAIL trig_on_rise got=%b want=1", trigger);
        end
    endtask

    task automatic test_trigger_off();
        logic [31:0] e;
        for (int k = 1; k <= 15; k++) begin
            send(32'd0, e);
            total++;
            if (trigger !== 1'b1 || pwr_avg !== e) begin
                bad++;
                $display("FAIL trig_off_hold_%0d got trig=%b avg=%0d want 1/%0d", k, trigger, pwr_avg, e);
            end
        end
        tick();
        total++;
        if (trigger !== 1'b0) begin
            bad++;
            $display("FAIL trig_off_fall got=%b want=0", trigger);
        end
`ifdef POWER_TRIGGER_PEAK_EN
        total++;
        if (peak_valid !== 1'b1 || peak_pwr !== 32'd93) begin
            bad++;
            $display("FAIL peak_report got v=%b pwr=%0d want 1/93", peak_valid, peak_pwr);
        end
        tick();
        total++;
        if (peak_valid !== 1'b0) begin
            bad++;
            $display("FAIL peak_strobe got=%b want=0", peak_valid);
        end
`endif
    endtask

    task automatic test_alternating();
        logic [31:0] e;
        do_reset();
        threshold = '1;
        for (int k = 1; k <= 15; k++) send(32'd100, e);
        // Live threshold gives above,above,above,not-above repeatedly.
        for (int k = 16; k <= 27; k++) begin
            send(32'd100, e);
            total++;
            if (trigger !== 1'b0) begin
                bad++;
                $display("FAIL alt_%0d got=%b want=0", k, trigger);
            end
            threshold = (((k - 16) % 4) == 3) ? 32'd150 : 32'd50;
        end
        for (int k = 28; k <= 31; k++) begin
            send(32'd100, e);
            total++;
            if (trigger !== 1'b0) begin
                bad++;
                $display("FAIL alt_run_%0d got=%b want=0", k, trigger);
            end
            threshold = 32'd50;
        end
        tick();
        total++;
        if (trigger !== 1'b1) begin
            bad++;
            $display("FAIL alt_run_rise got=%b want=1", trigger);
        end
    endtask

    task automatic test_equal_threshold();
        logic [31:0] e;
        do_reset();
        threshold = 32'd100;
        for (int k = 1; k <= 20; k++) send(32'd100, e);
        tick();
        total++;
        if (trigger !== 1'b0 || pwr_avg !== 32'd100) begin
            bad++;
            $display("FAIL equal_thr got trig=%b avg=%0d want 0/100", trigger, pwr_avg);
        end
    endtask

    task automatic test_max_value();
        logic [31:0] e;
        do_reset();
        threshold = '1;
        for (int k = 1; k <= 20; k++) begin
            send(32'hFFFF_FFFF, e);
            total++;
            if (pwr_avg !== e) begin
                bad++;
                $display("FAIL max_%0d got=%h want=%h", k, pwr_avg, e);
            end
        end
        total++;
        if (pwr_avg !== 32'hFFFF_FFFF || window_full !== 1'b1 || trigger !== 1'b0) begin
            bad++;
            $display("FAIL max_final got avg=%h full=%b trig=%b want ffffffff/1/0", pwr_avg, window_full, trigger);
        end
    endtask

    task automatic test_enable_gap();
        logic [31:0] e;
        logic [31:0] held;
        do_reset();
        threshold = '1;
        for (int i = 0; i < 8; i++) send(32'(1000 + 37 * i), e);
        held = e;
        tick();
        total++;
        if (pwr_avg_valid !== 1'b0 || pwr_avg !== held) begin
            bad++;
            $display("FAIL gap_idle got v=%b avg=%0d want 0/%0d", pwr_avg_valid, pwr_avg, held);
        end
        enable       = 1'b0;
        mag_sq_valid = 1'b1;
        mag_sq       = 32'h0000_DEAD;
        for (int c = 0; c < 5; c++) begin
            tick();
            total++;
            if (pwr_avg_valid !== 1'b0 || pwr_avg !== held || window_full !== 1'b0) begin
                bad++;
                $display("FAIL gap_hold_%0d got v=%b avg=%0d full=%b want 0/%0d/0", c, pwr_avg_valid, pwr_avg, window_full, held);
            end
        end
        enable       = 1'b1;
        mag_sq_valid = 1'b0;
        for (int i = 8; i < 24; i++) begin
            send(32'(1000 + 37 * i), e);
            total++;
            if (pwr_avg !== e || pwr_avg_valid !== 1'b1) begin
                bad++;
                $display("FAIL gap_resume_%0d got avg=%0d v=%b want %0d/1", i, pwr_avg, pwr_avg_valid, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] e;
        do_reset();
        threshold = 32'd50;
        for (int k = 1; k <= 20; k++) send(32'd100, e);
        tick();
        total++;
        if (trigger !== 1'b1) begin
            bad++;
            $display("FAIL rst_mid_pre got=%b want=1", trigger);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        hist.delete();
        total++;
        if (trigger !== 1'b0 || window_full !== 1'b0 || pwr_avg !== 32'd0 || pwr_avg_valid !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear got trig=%b full=%b avg=%0d v=%b want 0/0/0/0", trigger, window_full, pwr_avg, pwr_avg_valid);
        end
        for (int k = 1; k <= 16; k++) begin
            send(32'd40, e);
            total++;
            if (pwr_avg !== e || window_full !== (k == 16)) begin
                bad++;
                $display("FAIL rst_mid_fill_%0d got avg=%0d full=%b want %0d/%b", k, pwr_avg, window_full, e, (k == 16));
            end
        end
        send(32'd40, e);
        tick();
        total++;
        if (pwr_avg !== 32'd40 || trigger !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_final got avg=%0d trig=%b want 40/0", pwr_avg, trigger);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        enable       = 1'b1;
        mag_sq       = '0;
        mag_sq_valid = 1'b0;
        threshold    = '1;
        test_reset();
        test_fill();
        test_slide();
        test_trigger_on();
        test_trigger_off();
        test_alternating();
        test_equal_threshold();
        test_max_value();
        test_enable_gap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
